// File: rtl/wb_mem_pkg.sv
// Shared encodings for the MEM-stage Wishbone master: access sizes, FSM states,
// and the per-size alignment mask.
package wb_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'b000;
      SZ_HALF: return 3'b001;
      SZ_WORD: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/wb_mem_lane_align.sv
// Byte-lane steering: store select/data generation and load extraction with
// sign/zero extension. Purely combinational; shared with the fetch path.
module wb_lane_align
  import wb_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  logic [1:0]                  size_i,
  input  logic                        unsigned_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [DATA_W-1:0]           rdata_i,
  output logic [DATA_W/8-1:0]         sel_o,
  output logic [DATA_W-1:0]           wdata_o,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int SEL_W = DATA_W / 8;

  logic [SEL_W-1:0]  sel_mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] dmask;
  logic              msb;

  always_comb begin
    sel_mask = '1;
    wdata_o  = wdata_i;
    dmask    = '1;
    shifted  = rdata_i >> {off_i, 3'b000};
    msb      = shifted[DATA_W-1];
    // Aligned accesses let replication stand in for a lane shift.
    case (size_i)
      SZ_BYTE: begin
        sel_mask = SEL_W'(1);
        wdata_o  = {SEL_W{wdata_i[7:0]}};
        dmask    = DATA_W'(8'hFF);
        msb      = shifted[7];
      end
      SZ_HALF: begin
        sel_mask = SEL_W'(3);
        wdata_o  = {(SEL_W/2){wdata_i[15:0]}};
        dmask    = DATA_W'(16'hFFFF);
        msb      = shifted[15];
      end
      SZ_WORD: begin
        sel_mask = SEL_W'(4'hF);
        wdata_o  = {(SEL_W/4){wdata_i[31:0]}};
        dmask    = DATA_W'(32'hFFFF_FFFF);
        msb      = shifted[31];
      end
      default: ;
    endcase
    sel_o   = sel_mask << off_i;
    rdata_o = (!unsigned_i && msb) ? (shifted | ~dmask) : (shifted & dmask);
  end

endmodule

// File: rtl/wb_mem_master.sv
// Registered Wishbone B4 classic master for the MEM stage, one access in flight.
// Define WB_MEM_TIMEOUT_EN to fault accesses the slave never terminates.
module wb_mem_master
  import wb_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_W          = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_fault,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [SEL_W-1:0]  wb_sel,
  output logic              wb_we,
  output logic              wb_stb,
  output logic              wb_cyc,
  input  logic              wb_ack,
  input  logic              wb_err
);

  localparam int OFF_W = $clog2(SEL_W);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic              req_go, bad_req, tmo_expired;
  logic [OFF_W-1:0]  la_off;
  logic [1:0]        la_size;
  logic              la_uns;
  logic [SEL_W-1:0]  la_sel;
  logic [DATA_W-1:0] la_wdata, la_rdata;

  assign req_go  = req_valid & (mem_read | mem_write);
  assign bad_req = (|(alu_result[2:0] & align_mask(mem_size)))
                 | ((mem_size == SZ_DWORD) && (DATA_W == 32))
                 | (mem_read & mem_write);

  // Live request drives the lane logic at acceptance; latched copy thereafter.
  assign la_off  = (state_q == IDLE) ? alu_result[OFF_W-1:0] : off_q;
  assign la_size = (state_q == IDLE) ? mem_size : size_q;
  assign la_uns  = (state_q == IDLE) ? mem_unsigned : uns_q;

  wb_lane_align #(.DATA_W(DATA_W)) u_lane (
    .off_i      (la_off),
    .size_i     (la_size),
    .unsigned_i (la_uns),
    .wdata_i    (write_data),
    .rdata_i    (wb_dat_i),
    .sel_o      (la_sel),
    .wdata_o    (la_wdata),
    .rdata_o    (la_rdata)
  );

`ifdef WB_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == IDLE)     tmo_d = '0;
    else if (state_q == BUS) tmo_d = tmo_q + TMO_W'(1);
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (req_go) begin
          off_d   = alu_result[OFF_W-1:0];
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          rdata_d = '0;
          if (bad_req) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            fault_d = 1'b0;
            cyc_d   = 1'b1;
            we_d    = mem_write;
            adr_d   = {alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            sel_d   = la_sel;
            dat_d   = la_wdata;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // Error beats ack, and a real termination beats the timeout.
        if (wb_err) begin
          fault_d = 1'b1;
          cyc_d   = 1'b0;
          state_d = RESP;
        end else if (wb_ack) begin
          cyc_d   = 1'b0;
          state_d = RESP;
          if (!we_q) rdata_d = la_rdata;
        end else if (tmo_expired) begin
          fault_d = 1'b1;
          cyc_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign stall         = ((state_q == IDLE) && req_go) || (state_q == BUS);
  assign rsp_valid     = (state_q == RESP);
  assign mem_fault     = rsp_valid & fault_q;
  assign mem_read_data = rsp_valid ? rdata_q : '0;
  assign wb_adr        = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel        = sel_q;
  assign wb_we         = we_q;
  assign wb_cyc        = cyc_q;
  assign wb_stb        = cyc_q;

endmodule

// File: tb/tb_wb_mem_master.sv
// Directed bench for wb_mem_master (32-bit data, TIMEOUT_CYCLES=4).
module tb_wb_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] alu_result, write_data;
  logic        stall, rsp_valid, mem_fault;
  logic [31:0] mem_read_data;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;

  int total = 0;
  int bad   = 0;

  wb_mem_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_size      (mem_size),
    .mem_unsigned  (mem_unsigned),
    .alu_result    (alu_result),
    .write_data    (write_data),
    .stall         (stall),
    .rsp_valid     (rsp_valid),
    .mem_read_data (mem_read_data),
    .mem_fault     (mem_fault),
    .wb_adr        (wb_adr),
    .wb_dat_o      (wb_dat_o),
    .wb_dat_i      (wb_dat_i),
    .wb_sel        (wb_sel),
    .wb_we         (wb_we),
    .wb_stb        (wb_stb),
    .wb_cyc        (wb_cyc),
    .wb_ack        (wb_ack),
    .wb_err        (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in an IDLE cycle, then scramble the inputs while stalled.
  task automatic accept(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    alu_result   = addr;
    write_data   = wd;
    #1 chk("stall_at_accept", stall, 1'b1);
    step();
    mem_read     = 1'b1;
    mem_write    = ~wr;
    mem_size     = 2'd3;
    mem_unsigned = ~uns;
    alu_result   = 32'hFFFF_FFFF;
    write_data   = $urandom;
  endtask

  task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] rdat, input logic [3:0] exp_sel,
                         input logic [31:0] exp_adr, input logic [31:0] exp_data);
    accept(1'b1, 1'b0, sz, uns, addr, 32'h0);
    chk("ld_cyc", wb_cyc, 1'b1);
    chk("ld_stb", wb_stb, 1'b1);
    chk("ld_sel", wb_sel, exp_sel);
    chk("ld_adr", wb_adr, exp_adr);
    chk("ld_we", wb_we, 1'b0);
    chk("ld_no_rsp_yet", rsp_valid, 1'b0);
    wb_ack    = 1'b1;
    wb_dat_i  = rdat;
    req_valid = 1'b0;
    step();
    wb_ack   = 1'b0;
    wb_dat_i = $urandom;
    chk("ld_rsp", rsp_valid, 1'b1);
    chk("ld_data", mem_read_data, exp_data);
    chk("ld_fault", mem_fault, 1'b0);
    chk("ld_stall_resp", stall, 1'b0);
    chk("ld_cyc_drop", wb_cyc, 1'b0);
    step();
    chk("ld_rsp_one_cycle", rsp_valid, 1'b0);
  endtask

  task automatic do_fault(input string tag, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic [31:0] addr);
    accept(rd, wr, sz, 1'b0, addr, 32'h0);
    req_valid = 1'b0;
    chk({tag, "_cyc"}, wb_cyc, 1'b0);
    chk({tag, "_rsp"}, rsp_valid, 1'b1);
    chk({tag, "_fault"}, mem_fault, 1'b1);
    chk({tag, "_data"}, mem_read_data, 32'h0);
    step();
    chk({tag, "_rsp_one_cycle"}, rsp_valid, 1'b0);
    chk({tag, "_still_no_cyc"}, wb_cyc, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_size = 2'd0; mem_unsigned = 1'b0; alu_result = '0; write_data = '0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    step();
    step();
    chk("rst_stall", stall, 1'b0);
    chk("rst_rsp", rsp_valid, 1'b0);
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_stb", wb_stb, 1'b0);
    chk("rst_sel", wb_sel, 4'h0);
    chk("rst_adr", wb_adr, 32'h0);
    chk("rst_fault", mem_fault, 1'b0);
    chk("rst_data", mem_read_data, 32'h0);
    #3 rst_n = 1'b1;
    step();

    do_load(2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h100, 32'hDEAD_BEEF);
    do_load(2'd0, 1'b0, 32'h0000_0103, 32'h8000_0000, 4'b1000, 32'h100, 32'hFFFF_FF80);
    do_load(2'd0, 1'b1, 32'h0000_0103, 32'h8000_0000, 4'b1000, 32'h100, 32'h0000_0080);
    do_load(2'd1, 1'b0, 32'h0000_0102, 32'hABCD_1234, 4'b1100, 32'h100, 32'hFFFF_ABCD);
    do_load(2'd1, 1'b0, 32'h0000_0012, 32'h7FFF_0000, 4'b1100, 32'h010, 32'h0000_7FFF);
    do_load(2'd0, 1'b0, 32'h0000_0021, 32'h0000_7F00, 4'b0010, 32'h020, 32'h0000_007F);

    // SH with three wait states
    accept(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_1234);
    chk("sh_adr", wb_adr, 32'h200);
    chk("sh_sel", wb_sel, 4'b1100);
    chk("sh_dat", wb_dat_o, 32'h1234_1234);
    chk("sh_we", wb_we, 1'b1);
    chk("sh_cyc_c1", wb_cyc, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("sh_cyc_held", wb_cyc, 1'b1);
      chk("sh_stall_held", stall, 1'b1);
      chk("sh_adr_held", wb_adr, 32'h200);
      chk("sh_rsp_low", rsp_valid, 1'b0);
    end
    chk("sh_dat_held", wb_dat_o, 32'h1234_1234);
    wb_ack    = 1'b1;
    req_valid = 1'b0;
    step();
    wb_ack = 1'b0;
    chk("sh_rsp", rsp_valid, 1'b1);
    chk("sh_data_zero", mem_read_data, 32'h0);
    chk("sh_fault", mem_fault, 1'b0);
    chk("sh_stall_resp", stall, 1'b0);
    chk("sh_cyc_drop", wb_cyc, 1'b0);
    step();
    chk("sh_rsp_one_cycle", rsp_valid, 1'b0);

    do_fault("mis_lw", 1'b1, 1'b0, 2'd2, 32'h0000_0101);
    do_fault("mis_lh", 1'b1, 1'b0, 2'd1, 32'h0000_0105);
    do_fault("ill_dword", 1'b1, 1'b0, 2'd3, 32'h0000_0100);
    do_fault("ill_rdwr", 1'b1, 1'b1, 2'd2, 32'h0000_0100);

    // Request with neither read nor write passes straight through
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    #1 chk("nop_stall", stall, 1'b0);
    step();
    req_valid = 1'b0;
    chk("nop_cyc", wb_cyc, 1'b0);
    chk("nop_rsp", rsp_valid, 1'b0);

    // SB with err and ack together
    accept(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0105, 32'h0000_00AB);
    chk("sb_adr", wb_adr, 32'h104);
    chk("sb_sel", wb_sel, 4'b0010);
    chk("sb_dat", wb_dat_o, 32'hABAB_ABAB);
    wb_ack = 1'b1; wb_err = 1'b1; req_valid = 1'b0;
    step();
    wb_ack = 1'b0; wb_err = 1'b0;
    chk("err_rsp", rsp_valid, 1'b1);
    chk("err_fault", mem_fault, 1'b1);
    chk("err_cyc_drop", wb_cyc, 1'b0);
    step();
    chk("err_rsp_one_cycle", rsp_valid, 1'b0);

    // Reset in the middle of a bus cycle
    accept(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
    req_valid = 1'b0;
    chk("rstmid_cyc_before", wb_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_cyc_async", wb_cyc, 1'b0);
    chk("rstmid_stb_async", wb_stb, 1'b0);
    step();
    chk("rstmid_no_rsp", rsp_valid, 1'b0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmid_no_rsp_after", rsp_valid, 1'b0);
      chk("rstmid_no_cyc_after", wb_cyc, 1'b0);
    end

    // Silent slave
    accept(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
    req_valid = 1'b0;
    chk("tmo_cyc_c1", wb_cyc, 1'b1);
`ifdef WB_MEM_TIMEOUT_EN
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("tmo_cyc_held", wb_cyc, 1'b1);
    end
    step();
    chk("tmo_cyc_drop", wb_cyc, 1'b0);
    chk("tmo_rsp", rsp_valid, 1'b1);
    chk("tmo_fault", mem_fault, 1'b1);
    step();
    chk("tmo_rsp_one_cycle", rsp_valid, 1'b0);
`else
    repeat (100) step();
    chk("notmo_cyc_held", wb_cyc, 1'b1);
    chk("notmo_no_rsp", rsp_valid, 1'b0);
    chk("notmo_stall", stall, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
